truth_table_sequencer: RTL and testbench

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

---
 rtl/truth_table_sequencer_pkg.sv | 25 ++
 rtl/tt_result_buf.sv | 25 ++
 rtl/truth_table_sequencer.sv | 148 ++++++++++++++
 tb/tb_truth_table_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_sequencer_pkg.sv
// Shared encodings and sizing for the truth-table sequencer and its result buffer.
// Also holds the helper that picks one vector's golden response out of the packed table.
package truth_table_sequencer_pkg;

    localparam int VEC_COUNT = 8;
    localparam int VEC_W     = 3;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Golden {f1,f2,f3} for vector i; vector i sits at bits [3i+2:3i].
    function automatic logic [VEC_W-1:0] golden_slice(
        input logic [VEC_COUNT*VEC_W-1:0] tbl,
        input logic [2:0]                 i
    );
        return tbl[VEC_W*i +: VEC_W];
    endfunction

endpackage

// File: rtl/tt_result_buf.sv
// 8x3 result buffer: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; readers qualify with results_valid.
module tt_result_buf
    import truth_table_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [2:0]       waddr,
    input  logic [VEC_W-1:0] wdata,
    input  logic [2:0]       raddr,
    output logic [VEC_W-1:0] rdata
);

    logic [VEC_W-1:0] mem_r [VEC_COUNT];

    // Capture one vector's response when the sequencer is in CAPTURE.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps {a,b,c} through all 8 input combinations, waits for the external logic to
// settle, captures {f1,f2,f3} per vector and counts mismatches against a golden table.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [23:0] EXPECTED      = 24'h000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       f1,
    input  logic       f2,
    input  logic       f3,
    output logic       busy,
    output logic       done,
    output logic       results_valid,
    input  logic [2:0] rd_addr,
    output logic [2:0] rd_data,
    output logic [3:0] mismatch_cnt,
    output logic       pass
);

    state_e           state_r, state_s;
    logic [2:0]       idx_r, idx_s;
    logic [CNT_W-1:0] settle_cnt_r, settle_cnt_s;
    logic [2:0]       abc_r, abc_s;
    logic [3:0]       mism_r, mism_s;
    logic             valid_r, valid_s;
    logic             busy_r, done_r, pass_r;
    logic             we_s;
    logic [VEC_W-1:0] cap_s;

    assign cap_s = {f1, f2, f3};

    // Next-state, datapath updates and buffer write strobe.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        settle_cnt_s = settle_cnt_r;
        abc_s        = abc_r;
        mism_s       = mism_r;
        valid_s      = valid_r;
        we_s         = 1'b0;
        if ((state_r != ST_IDLE) && abort) begin
            // Cancelled sweep: results_valid is already low since start cleared it.
            state_s = ST_IDLE;
            abc_s   = 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !abort) begin
                        idx_s   = 3'd0;
                        mism_s  = 4'd0;
                        valid_s = 1'b0;
                        state_s = ST_DRIVE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    abc_s        = idx_r;
                    settle_cnt_s = CNT_W'(SETTLE_CYCLES - 1);
                    state_s      = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == {CNT_W{1'b0}}) begin
                        state_s = ST_CAPTURE;
                    end else begin
                        settle_cnt_s = settle_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_CAPTURE: begin
                    we_s = 1'b1;
                    if (cap_s != golden_slice(EXPECTED, idx_r)) begin
                        mism_s = mism_r + 4'd1;
                    end else begin
                        mism_s = mism_r;
                    end
                    if (idx_r == 3'd7) begin
                        // Stimulus returns to zero for the DONE cycle.
                        abc_s   = 3'd0;
                        valid_s = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        idx_s   = idx_r + 3'd1;
                        state_s = ST_DRIVE;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                    abc_s   = 3'd0;
                end
            endcase
        end
    end

    // State and registered outputs; buffer contents are kept out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= 3'd0;
            settle_cnt_r <= {CNT_W{1'b0}};
            abc_r        <= 3'd0;
            mism_r       <= 4'd0;
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            settle_cnt_r <= settle_cnt_s;
            abc_r        <= abc_s;
            mism_r       <= mism_s;
            valid_r      <= valid_s;
            busy_r       <= (state_s != ST_IDLE);
            done_r       <= (state_s == ST_DONE);
            pass_r       <= valid_s && (mism_s == 4'd0);
        end
    end

    tt_result_buf u_buf (
        .clk   (clk),
        .we    (we_s),
        .waddr (idx_r),
        .wdata (cap_s),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign a             = abc_r[2];
    assign b             = abc_r[1];
    assign c             = abc_r[0];
    assign busy          = busy_r;
    assign done          = done_r;
    assign results_valid = valid_r;
    assign mismatch_cnt  = mism_r;
    assign pass          = pass_r;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: four instances (settle 2 good/bad golden, settle 1, settle 15)
// share stimulus; a timeline model predicts every output each cycle, plus literal pins.
module tb_truth_table_sequencer;

    localparam int          NI       = 4;
    localparam int          SET [NI] = '{2, 2, 1, 15};
    localparam logic [23:0] EXPS[NI] = '{24'hF93458, 24'hF93459, 24'hF93458, 24'hF93458};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [2:0] rd_addr = 3'd0;

    logic [NI-1:0] a_w, b_w, c_w, f1_w, f2_w, f3_w, busy_w, done_w, valid_w, pass_w;
    logic [NI-1:0][2:0] rd_w;
    logic [NI-1:0][3:0] mc_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign f1_w[g] = a_w[g] & b_w[g];
        assign f2_w[g] = a_w[g] | c_w[g];
        assign f3_w[g] = a_w[g] ^ b_w[g] ^ c_w[g];
        truth_table_sequencer #(.SETTLE_CYCLES(SET[g]), .EXPECTED(EXPS[g])) dut (
            .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
            .a(a_w[g]), .b(b_w[g]), .c(c_w[g]),
            .f1(f1_w[g]), .f2(f2_w[g]), .f3(f3_w[g]),
            .busy(busy_w[g]), .done(done_w[g]), .results_valid(valid_w[g]),
            .rd_addr(rd_addr), .rd_data(rd_w[g]), .mismatch_cnt(mc_w[g]), .pass(pass_w[g])
        );
    end

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] ffun(input int v);
        logic [2:0] t;
        t = 3'(v);
        return {t[2] & t[1], t[2] | t[0], ^t};
    endfunction

    // Model: e = edges since the accepting edge (-1 when idle); sweep length 8*(S+2).
    int         e    [NI] = '{default: -1};
    bit         mv   [NI] = '{default: 1'b0};
    int         mm   [NI] = '{default: 0};
    logic [2:0] mbuf [NI][8];
    int         acc  [NI] = '{default: 0};
    int         lat  [NI] = '{default: -1};
    int         cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        int p, l, v;
        logic [2:0]  cap;
        logic [23:0] sh;
        if (!rst_n) begin
            for (int k = 0; k < NI; k++) begin
                e[k] = -1; mv[k] = 1'b0; mm[k] = 0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < NI; k++) begin
                p = SET[k] + 2;
                l = 8 * p;
                if (e[k] < 0) begin
                    if (start && !abort) begin
                        e[k] = 0; mv[k] = 1'b0; mm[k] = 0; acc[k] = cyc;
                    end
                end else if (abort) begin
                    e[k] = -1;
                end else begin
                    if (e[k] % p == p - 1) begin
                        v = e[k] / p;
                        cap = ffun(v);
                        mbuf[k][v] = cap;
                        sh = EXPS[k] >> (3 * v);
                        if (cap != sh[2:0]) mm[k]++;
                    end
                    if (e[k] == l) e[k] = -1;
                    else begin
                        e[k]++;
                        if (e[k] == l) mv[k] = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        int p, l, v, ph;
        logic [2:0] eabc;
        for (int k = 0; k < NI; k++) begin
            p = SET[k] + 2;
            l = 8 * p;
            if (e[k] < 0 || e[k] == l) eabc = 3'd0;
            else begin
                v = e[k] / p;
                ph = e[k] % p;
                eabc = (ph == 0) ? ((v == 0) ? 3'd0 : 3'(v - 1)) : 3'(v);
            end
            check("abc", k, 32'({a_w[k], b_w[k], c_w[k]}), 32'(eabc));
            check("busy", k, 32'(busy_w[k]), 32'(e[k] >= 0));
            check("done", k, 32'(done_w[k]), 32'(e[k] == l));
            check("results_valid", k, 32'(valid_w[k]), 32'(mv[k]));
            check("mismatch_cnt", k, 32'(mc_w[k]), 32'(mm[k]));
            check("pass", k, 32'(pass_w[k]), 32'(mv[k] && mm[k] == 0));
            if (mv[k]) check("rd_data", k, 32'(rd_w[k]), 32'(mbuf[k][rd_addr]));
            if (done_w[k] === 1'b1) lat[k] = cyc - acc[k];
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_latencies();
        check("latency", 0, 32'(lat[0]), 32'd32);
        check("latency", 1, 32'(lat[1]), 32'd32);
        check("latency", 2, 32'(lat[2]), 32'd24);
        check("latency", 3, 32'(lat[3]), 32'd136);
    endtask

    task automatic check_quiet(input string name);
        for (int k = 0; k < NI; k++) begin
            check({name, "_busy"}, k, 32'(busy_w[k]), 32'd0);
            check({name, "_abc"}, k, 32'({a_w[k], b_w[k], c_w[k]}), 32'd0);
            check({name, "_done"}, k, 32'(done_w[k]), 32'd0);
            check({name, "_valid"}, k, 32'(valid_w[k]), 32'd0);
        end
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Sweep A, with a start pulse at cycle 5 that must be ignored.
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (140) tick();
        check_latencies();
        check("good_mismatch", 0, 32'(mc_w[0]), 32'd0);
        check("good_pass", 0, 32'(pass_w[0]), 32'd1);
        check("bad_valid", 1, 32'(valid_w[1]), 32'd1);
        check("bad_mismatch", 1, 32'(mc_w[1]), 32'd1);
        check("bad_pass", 1, 32'(pass_w[1]), 32'd0);
        rd_addr = 3'd5;
        #1;
        check("buf5", 0, 32'(rd_w[0]), 32'h2);
        rd_addr = 3'd0;
        #1;
        check("buf0", 1, 32'(rd_w[1]), 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            tick();
        end

        // start and abort together while idle: nothing starts, results hold.
        start = 1'b1; abort = 1'b1; tick();
        start = 1'b0; abort = 1'b0; tick();
        check("st_ab_busy", 0, 32'(busy_w[0]), 32'd0);
        check("hold_valid", 0, 32'(valid_w[0]), 32'd1);
        check("hold_mismatch", 1, 32'(mc_w[1]), 32'd1);

        // Sweep B aborted at cycle 10.
        start = 1'b1; tick(); start = 1'b0;
        repeat (9) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check_quiet("abort");
        repeat (3) tick();

        // Sweep C completes normally after the abort.
        for (int k = 0; k < NI; k++) lat[k] = -1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (140) tick();
        check_latencies();
        check("again_pass", 0, 32'(pass_w[0]), 32'd1);

        // Sweep D killed by reset at cycle 17.
        start = 1'b1; tick(); start = 1'b0;
        repeat (17) tick();
        rst_n = 1'b0;
        #1;
        check_quiet("reset");
        check("reset_mismatch", 1, 32'(mc_w[1]), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
